// File: rtl/axi_sram_write_slave_if.sv
// AXI write-path bundle (AW, W, B channels) between a master and the SRAM write slave.
interface axi_sram_write_slave_if #(
  parameter int ID_BITS   = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4
);
  logic [ID_BITS-1:0]     AWID;
  logic [ADDR_BITS-1:0]   AWADDR;
  logic [LEN_BITS-1:0]    AWLEN;
  logic [1:0]             AWBURST;
  logic                   AWVALID;
  logic                   AWREADY;
  logic [DATA_BITS-1:0]   WDATA;
  logic [DATA_BITS/8-1:0] WSTRB;
  logic                   WLAST;
  logic                   WVALID;
  logic                   WREADY;
  logic [ID_BITS-1:0]     BID;
  logic [1:0]             BRESP;
  logic                   BVALID;
  logic                   BREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/axi_sram_write_slave.sv
// AXI write slave: one burst at a time, each W beat becomes a single-cycle SRAM byte write,
// followed by a B response.
//   state   | meaning
//   S_INIT  | held in reset, all outputs low
//   S_IDLE  | waiting for an AW handshake
//   S_WDATA | accepting W beats until WLAST
//   S_RESP  | presenting B response until BREADY
module axi_sram_write_slave #(
  parameter int ID_BITS   = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int MEM_AW    = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_sram_write_slave_if.slave  axi,
  output logic                   mem_we,
  output logic [DATA_BITS/8-1:0] mem_bwe,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [DATA_BITS-1:0]   mem_di
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WDATA, S_RESP} state_t;

  // beat counter is one bit wider than AWLEN so it can saturate at 2^LEN_BITS
  localparam logic [LEN_BITS:0] CNT_MAX = {1'b1, {LEN_BITS{1'b0}}};

  state_t              state_q, state_d;
  logic [ID_BITS-1:0]  id_q;
  logic [MEM_AW-1:0]   addr_q;
  logic [LEN_BITS-1:0] len_q;
  logic                incr_q;
  logic [LEN_BITS:0]   cnt_q;
  logic                err_q;
  logic                in_range;

  assign in_range = (cnt_q <= {1'b0, len_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BID     = '0;
    axi.BRESP   = 2'b00;
    mem_we      = 1'b0;
    mem_bwe     = '0;
    mem_addr    = '0;
    mem_di      = '0;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        axi.AWREADY = 1'b1;
        if (axi.AWVALID) state_d = S_WDATA;
      end
      S_WDATA: begin
        axi.WREADY = 1'b1;
        if (axi.WVALID) begin
          if (!err_q && in_range) begin
            mem_we   = 1'b1;
            mem_bwe  = axi.WSTRB;
            mem_addr = addr_q;
            mem_di   = axi.WDATA;
          end
          if (axi.WLAST) state_d = S_RESP;
        end
      end
      S_RESP: begin
        axi.BVALID = 1'b1;
        axi.BID    = id_q;
        axi.BRESP  = err_q ? 2'b10 : 2'b00;
        if (axi.BREADY) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      incr_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (state_q == S_IDLE && axi.AWVALID) begin
      id_q   <= axi.AWID;
      addr_q <= axi.AWADDR[MEM_AW+1:2];
      len_q  <= axi.AWLEN;
      incr_q <= (axi.AWBURST == 2'b01);
      cnt_q  <= '0;
      err_q  <= axi.AWBURST[1];
    end else if (state_q == S_WDATA && axi.WVALID) begin
      if (incr_q) addr_q <= addr_q + 1'b1;
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      // WLAST anywhere but beat AWLEN (early, or late after dropped beats) is an error
      if (axi.WLAST && (cnt_q != {1'b0, len_q})) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_sram_write_slave.sv
// Scoreboard bench for axi_sram_write_slave: directed and random bursts, expected SRAM writes
// and B responses are queued by the driver and consumed by a negedge monitor.
module tb_axi_sram_write_slave;
  localparam int ID_BITS = 8, ADDR_BITS = 32, DATA_BITS = 32, LEN_BITS = 4, MEM_AW = 14;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_write_slave_if #(.ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS),
                            .DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS)) axi ();
  logic              mem_we;
  logic [3:0]        mem_bwe;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_di;

  axi_sram_write_slave #(.ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
                         .LEN_BITS(LEN_BITS), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst), .axi(axi),
    .mem_we(mem_we), .mem_bwe(mem_bwe), .mem_addr(mem_addr), .mem_di(mem_di)
  );

  typedef struct { logic [MEM_AW-1:0] addr; logic [3:0] bwe; logic [31:0] data; } wr_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } b_t;
  wr_t wq[$];
  b_t  bq[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] dat[16];
  logic [3:0]  stb[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout_%s actual=no_handshake required=handshake", name);
  endtask

  // monitor: pops expectations whenever the DUT writes SRAM or completes a B handshake
  logic       prev_bv = 1'b0, prev_br = 1'b0;
  logic [7:0] prev_bid = '0;
  logic [1:0] prev_bresp = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_bv = 1'b0;
      prev_br = 1'b0;
    end else begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=addr_%0h required=no_write", mem_addr);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          check("mem_bwe",  64'(mem_bwe),  64'(e.bwe));
          check("mem_di",   64'(mem_di),   64'(e.data));
        end
      end else begin
        check("mem_idle_zero", {14'd0, mem_bwe, mem_addr, mem_di}, 64'd0);
      end
      if (prev_bv && !prev_br)
        check("b_hold", {53'd0, axi.BVALID, axi.BID, axi.BRESP}, {53'd0, 1'b1, prev_bid, prev_bresp});
      if (axi.BVALID && axi.BREADY) begin
        if (bq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_b actual=bid_%0h required=no_response", axi.BID);
        end else begin
          b_t e;
          e = bq.pop_front();
          check("bid",   64'(axi.BID),   64'(e.id));
          check("bresp", 64'(axi.BRESP), 64'(e.resp));
        end
      end
      prev_bv    = axi.BVALID;
      prev_br    = axi.BREADY;
      prev_bid   = axi.BID;
      prev_bresp = axi.BRESP;
    end
  end

  // reference: expected writes and response follow directly from the burst parameters
  task automatic predict(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int nbeats);
    bit legal;
    legal = (burst == 2'b00) || (burst == 2'b01);
    for (int i = 0; i < nbeats; i++)
      if (legal && i <= int'(len))
        wq.push_back('{addr: MEM_AW'(int'(addr[15:2]) + ((burst == 2'b01) ? i : 0)),
                       bwe: stb[i], data: dat[i]});
    bq.push_back('{id: id, resp: (legal && nbeats == int'(len) + 1) ? 2'b00 : 2'b10});
  endtask

  // all drivers start and end at posedge+1
  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
    int n = 0;
    axi.AWID = id; axi.AWADDR = addr; axi.AWLEN = len; axi.AWBURST = burst; axi.AWVALID = 1'b1;
    @(negedge clk);
    while (!axi.AWREADY && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout("aw");
    @(posedge clk); #1;
    axi.AWVALID = 1'b0;
    @(negedge clk);
    check("wready_latency", 64'(axi.WREADY), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input int i, input bit last, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    axi.WDATA = dat[i]; axi.WSTRB = stb[i]; axi.WLAST = last; axi.WVALID = 1'b1;
    @(negedge clk);
    while (!axi.WREADY && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout("w");
    @(posedge clk); #1;
    axi.WVALID = 1'b0;
    axi.WLAST  = 1'b0;
  endtask

  task automatic finish_b(input int bdelay);
    int n = 0;
    @(negedge clk);
    check("bvalid_latency", 64'(axi.BVALID), 64'd1);
    @(posedge clk); #1;
    repeat (bdelay) begin @(posedge clk); #1; end
    axi.BREADY = 1'b1;
    @(negedge clk);
    while (!axi.BVALID && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout("b");
    @(posedge clk); #1;
    axi.BREADY = 1'b0;
  endtask

  task automatic do_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input int nbeats, input int gapmax,
                          input int bdelay);
    predict(id, addr, len, burst, nbeats);
    send_aw(id, addr, len, burst);
    for (int i = 0; i < nbeats; i++)
      send_beat(i, i == nbeats - 1, $urandom_range(0, gapmax));
    finish_b(bdelay);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      dat[i] = $urandom;
      stb[i] = 4'($urandom);
    end
  endtask

  initial begin
    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWBURST = '0; axi.AWVALID = 1'b0;
    axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {61'd0, axi.AWREADY, axi.WREADY, axi.BVALID}, 64'd0);
    check("reset_we", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("init_awready", 64'(axi.AWREADY), 64'd0);
    @(negedge clk);
    check("idle_awready", 64'(axi.AWREADY), 64'd1);
    @(posedge clk); #1;

    // single INCR beat
    dat[0] = 32'hDEADBEEF; stb[0] = 4'hF;
    do_burst(8'h21, 32'h10, 4'd0, 2'b01, 1, 0, 0);
    // INCR with gaps and B backpressure
    fill_random();
    do_burst(8'h35, 32'h0, 4'd3, 2'b01, 4, 2, 3);
    // FIXED with single-lane strobes
    fill_random();
    stb[0] = 4'h1; stb[1] = 4'h2; stb[2] = 4'h4;
    do_burst(8'h44, 32'h0000_0120, 4'd2, 2'b00, 3, 1, 1);
    // SRAM top wrap
    fill_random();
    do_burst(8'h50, 32'h0000_FFFC, 4'd1, 2'b01, 2, 0, 0);
    // unsupported burst type
    fill_random();
    do_burst(8'h61, 32'h40, 4'd1, 2'b10, 2, 1, 0);
    // early WLAST
    fill_random();
    do_burst(8'h72, 32'h80, 4'd3, 2'b01, 2, 0, 1);
    // late WLAST, extra beats dropped
    fill_random();
    do_burst(8'h83, 32'hC0, 4'd1, 2'b01, 4, 1, 0);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] len;
      logic [1:0] burst;
      int nb;
      fill_random();
      len   = 4'($urandom_range(0, 7));
      burst = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      nb    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 12) : int'(len) + 1;
      do_burst(8'($urandom), $urandom, len, burst, nb, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // reset in the middle of a 4-beat burst after 2 beats
    fill_random();
    wq.push_back('{addr: MEM_AW'(14'h0100), bwe: stb[0], data: dat[0]});
    wq.push_back('{addr: MEM_AW'(14'h0101), bwe: stb[1], data: dat[1]});
    send_aw(8'h99, 32'h0000_0400, 4'd3, 2'b01);
    send_beat(0, 1'b0, 0);
    send_beat(1, 1'b0, 0);
    axi.WDATA = dat[2]; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rst_ctrl", {53'd0, axi.AWREADY, axi.WREADY, axi.BVALID, axi.BID, axi.BRESP}, 64'd0);
    check("rst_mem", {13'd0, mem_we, mem_bwe, mem_addr, mem_di}, 64'd0);
    axi.WVALID = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_init_awready", 64'(axi.AWREADY), 64'd0);
    @(negedge clk);
    check("rst_idle_awready", 64'(axi.AWREADY), 64'd1);
    @(posedge clk); #1;
    fill_random();
    do_burst(8'hA5, 32'h0000_0200, 4'd0, 2'b01, 1, 0, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("writes_drained", 64'(wq.size()), 64'd0);
    check("resps_drained", 64'(bq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/axi_sram_write_slave.md
Name: axi_sram_write_slave

Overview:
AXI write-path slave front end (AW, W, B channels) for one SRAM-backed slave port. It accepts one write burst at a time, converts W beats into single-cycle SRAM byte writes, and returns a B response. It sits directly upstream of the interconnect write-response mux: its BID/BRESP/BVALID/BREADY connect to one slave-side B port (S0/S1/S2) of that mux.

Parameters:
ID_BITS, 8, width of the slave-side ID (master tag plus master ID, equal to AXI_IDS_BITS).
ADDR_BITS, 32, AXI address width.
DATA_BITS, 32, AXI data width (4 byte lanes).
LEN_BITS, 4, AWLEN width.
MEM_AW, 14, SRAM word-address width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
AWID  in  ID_BITS  write address ID.
AWADDR  in  ADDR_BITS  byte address of first beat.
AWLEN  in  LEN_BITS  beats minus 1.
AWBURST  in  2  00=FIXED, 01=INCR, others unsupported.
AWVALID  in  1  address valid.
AWREADY  out  1  address ready.
WDATA  in  DATA_BITS  write data.
WSTRB  in  DATA_BITS/8  byte strobes.
WLAST  in  1  last beat flag.
WVALID  in  1  data valid.
WREADY  out  1  data ready.
BID  out  ID_BITS  response ID.
BRESP  out  2  00=OKAY, 10=SLVERR.
BVALID  out  1  response valid.
BREADY  in  1  response ready.
mem_we  out  1  SRAM write strobe, one cycle per written beat.
mem_bwe  out  DATA_BITS/8  SRAM byte write enables, active-high.
mem_addr  out  MEM_AW  SRAM word address.
mem_di  out  DATA_BITS  SRAM write data.

Behaviour:
- States: INIT, IDLE, WDATA, RESP. INIT is held while rst=1 and exits to IDLE on the first clk edge after release.
- All outputs are 0 in INIT. AWREADY=1 only in IDLE, WREADY=1 only in WDATA, BVALID=1 only in RESP.
- IDLE: on AWVALID&AWREADY, latch AWID, AWADDR[MEM_AW+1:2] as cur_addr, AWLEN and AWBURST. Clear beat count and error flag. Set err if AWBURST is neither 00 nor 01. Go to WDATA the next cycle.
- WDATA: each WVALID&WREADY is one beat.
  - If err=0 and beat count<=AWLEN: in the same cycle drive mem_we=1, mem_bwe=WSTRB, mem_addr=cur_addr, mem_di=WDATA.
  - Otherwise: mem_we=0.
  - mem_bwe, mem_addr and mem_di are 0 whenever mem_we=0.
- Address update after each beat: INCR advances cur_addr by 1 modulo 2^MEM_AW (wraps at the SRAM top); FIXED leaves it unchanged.
- The burst terminates only on a beat with WLAST=1, then goes to RESP the next cycle.
  - WLAST on beat index != AWLEN sets SLVERR. This covers early WLAST, and late WLAST where the extra beats are accepted and dropped.
  - Beat count saturates at 2^LEN_BITS; no wrap.
- RESP: BID=latched AWID. BRESP=10 if err, else 00. BVALID is held with BID/BRESP stable until BREADY=1.
  - On BVALID&BREADY, go to IDLE the next cycle. AWREADY is 0 in the handshake cycle, so there is at least one bubble between bursts.
- Only one outstanding burst. W beats presented in IDLE or RESP are not accepted (WREADY=0).
- Latency:
  - AW handshake at cycle t gives WREADY=1 at t+1.
  - Last-beat handshake at t gives BVALID=1 at t+1.
  - SRAM write occurs in the beat's handshake cycle.
- Reset mid-operation: immediate return to INIT with all outputs 0. SRAM contents already written are kept, and no B response is issued for the aborted burst.

Test Plan:
- Single INCR: AWID=8'h21, AWADDR=0x10, AWLEN=0, one beat WDATA=0xDEADBEEF, WSTRB=4'hF, WLAST=1 -> mem_we one cycle at mem_addr=4, then BVALID with BID=8'h21, BRESP=00.
- INCR burst with backpressure: AWADDR=0x0, AWLEN=3, WVALID gapped, BREADY held 0 for 3 cycles -> writes at word addresses 0,1,2,3 only on handshake cycles; BVALID, BID and BRESP stable until BREADY=1.
- FIXED and strobes: AWBURST=00, AWLEN=2, WSTRB=1,2,4 -> three writes all at the same mem_addr with mem_bwe=1,2,4; BRESP=00.
- Wrap-around: AWADDR=word 0x3FFF, AWLEN=1 INCR -> writes at 0x3FFF then 0x0000.
- Errors:
  - AWBURST=10 -> beats accepted, mem_we never 1, BRESP=10.
  - AWLEN=3 with WLAST on beat 1 -> 2 writes, BRESP=10.
  - AWLEN=1 with WLAST on beat 3 -> 2 writes, 2 dropped, BRESP=10.
- Reset: assert rst mid-burst after 2 of 4 beats -> all outputs 0 immediately; AWREADY=1 one cycle after release; a following single-beat burst completes normally with OKAY.
